// File: rtl/two_level_sweep_if.sv
// rtl/two_level_sweep_if.sv - sweep control and stimulus/capture bus for two_level_sweep
//
// Signals:
//   start      run request from the controller
//   expected   golden 16-entry truth table, latched when a run is accepted
//   f_in       f output of the two_level stage being swept
//   a,b,c,d    stimulus to two_level; {a,b,c,d} is the vector index, a is the MSB
//   busy       run in progress
//   done       one-cycle end-of-run pulse
//   table_out  captured truth table, bit i = f_in while the index was i
//   pass       table_out matched the latched golden table
// Modports:
//   master  controller / environment side (drives start, expected, f_in)
//   slave   the sweep engine
interface two_level_sweep_if;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        pass;

    modport master (
        output start,
        output expected,
        output f_in,
        input  a,
        input  b,
        input  c,
        input  d,
        input  busy,
        input  done,
        input  table_out,
        input  pass
    );

    modport slave (
        input  start,
        input  expected,
        input  f_in,
        output a,
        output b,
        output c,
        output d,
        output busy,
        output done,
        output table_out,
        output pass
    );
endinterface

// File: rtl/two_level_sweep.sv
// rtl/two_level_sweep.sv - exhaustive 16-vector stimulus and truth-table capture for two_level
//
// Walks {a,b,c,d} through 0..15, waits SETTLE idle cycles per vector, samples
// f_in into a 16-bit table and compares it with the golden table latched at start.
//
// Parameters:
//   SETTLE  idle cycles between driving a vector and sampling f_in (0..15)
// Ports:
//   i_clk   clock, all state changes on the rising edge
//   i_rst   synchronous active-high reset, overrides a simultaneous start
//   bus     two_level_sweep_if.slave: start/expected/f_in in, a..d/busy/done/table_out/pass out
module two_level_sweep #(
    parameter int unsigned SETTLE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    two_level_sweep_if.slave  bus
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);
    localparam logic [3:0] LP_LAST   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_wcnt;
    logic [15:0] r_exp;
    logic [15:0] r_table;
    logic        r_pass;
    logic        r_done;
    logic        r_busy;

    // Table as it will look after the final sample; the verdict has to be
    // computed in the same cycle that bit 15 is written.
    logic [15:0] w_final_table;
    assign w_final_table = {bus.f_in, r_table[14:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_wcnt  <= 4'd0;
            r_exp   <= 16'd0;
            r_table <= 16'd0;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_idx   <= 4'd0;
                        r_table <= 16'd0;
                        r_pass  <= 1'b0;
                        r_exp   <= bus.expected;
                        r_wcnt  <= LP_SETTLE;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // The vector has been on a..d since the edge entering
                    // SETTLE; SAMPLE follows once the countdown expires.
                    if (r_wcnt == 4'd0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_table[r_idx] <= bus.f_in;
                    if (r_idx == LP_LAST) begin
                        r_pass  <= (w_final_table == r_exp);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_wcnt  <= LP_SETTLE;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here; a held start
                    // is picked up in the IDLE cycle that follows.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stimulus comes straight from the index register so a..d are glitch-free
    // and hold 1111 after a completed run.
    assign bus.a         = r_idx[3];
    assign bus.b         = r_idx[2];
    assign bus.c         = r_idx[1];
    assign bus.d         = r_idx[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.table_out = r_table;
    assign bus.pass      = r_pass;

endmodule

// File: tb/tb_two_level_sweep.sv
// tb/tb_two_level_sweep.sv - scoreboard bench for two_level_sweep with SETTLE=1 and SETTLE=0 instances
module tb_two_level_sweep;

    typedef struct {
        int          acc;   // edge at which start is accepted
        logic [15:0] tt;    // truth table f_in will follow during the run
        logic [15:0] gold;  // expected value presented at accept time
    } run_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    logic        rst_v   [2];
    logic        start_v [2];
    logic [15:0] exp_v   [2];
    logic [15:0] tt_drv  [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        pass_v  [2];
    logic [15:0] tbl_v   [2];
    logic [3:0]  vec_v   [2];

    run_t        runs   [2][$];
    logic [15:0] st_tbl [2];
    logic        st_pass[2];
    logic [3:0]  st_vec [2];

    bit fin_req = 1'b0;
    bit fin_ack = 1'b0;

    // Instance 0 uses SETTLE=1, instance 1 uses SETTLE=0.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        two_level_sweep_if ifc ();
        assign ifc.start    = start_v[g];
        assign ifc.expected = exp_v[g];
        assign ifc.f_in     = tt_drv[g][{ifc.a, ifc.b, ifc.c, ifc.d}];
        assign busy_v[g]    = ifc.busy;
        assign done_v[g]    = ifc.done;
        assign pass_v[g]    = ifc.pass;
        assign tbl_v[g]     = ifc.table_out;
        assign vec_v[g]     = {ifc.a, ifc.b, ifc.c, ifc.d};

        two_level_sweep #(.SETTLE((g == 0) ? 1 : 0)) u_dut (
            .i_clk (clk),
            .i_rst (rst_v[g]),
            .bus   (ifc)
        );
    end

    function automatic int period(input int g);
        return (g == 0) ? 3 : 2;  // SETTLE + 2
    endfunction

    // Behavioural two_level: f is low only for a=1,b=1,c=0,d=0.
    function automatic logic two_level_f(input logic a, input logic b, input logic c, input logic d);
        return ~a | ~b | c | d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h required %0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Monitor: derives every output from the run queue and elapsed cycles.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin : per_dut
            int          p;
            int          l;
            int          k;
            run_t        r;
            logic        e_busy;
            logic        e_done;
            logic        e_pass;
            logic [15:0] e_tbl;
            logic [3:0]  e_vec;
            p      = period(g);
            l      = 16 * p;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_tbl  = st_tbl[g];
            e_pass = st_pass[g];
            e_vec  = st_vec[g];
            if (rst_v[g]) begin
                runs[g].delete();
                st_tbl[g]  = 16'h0;
                st_pass[g] = 1'b0;
                st_vec[g]  = 4'h0;
                e_tbl      = 16'h0;
                e_pass     = 1'b0;
                e_vec      = 4'h0;
            end else if (runs[g].size() > 0) begin
                r = runs[g][0];
                if (cyc >= r.acc && cyc < r.acc + l) begin
                    k      = (cyc - r.acc) / p;
                    e_busy = 1'b1;
                    e_vec  = 4'(k);
                    e_tbl  = r.tt & ((16'h1 << k) - 16'h1);
                    e_pass = 1'b0;
                end else if (cyc == r.acc + l) begin
                    e_done     = 1'b1;
                    e_vec      = 4'hF;
                    e_tbl      = r.tt;
                    e_pass     = (r.tt == r.gold);
                    st_tbl[g]  = e_tbl;
                    st_pass[g] = e_pass;
                    st_vec[g]  = e_vec;
                    void'(runs[g].pop_front());
                end
            end
            chk($sformatf("u%0d.busy", g),  32'(busy_v[g]), 32'(e_busy));
            chk($sformatf("u%0d.done", g),  32'(done_v[g]), 32'(e_done));
            chk($sformatf("u%0d.pass", g),  32'(pass_v[g]), 32'(e_pass));
            chk($sformatf("u%0d.table", g), 32'(tbl_v[g]),  32'(e_tbl));
            chk($sformatf("u%0d.abcd", g),  32'(vec_v[g]),  32'(e_vec));
        end
        if (fin_req && !fin_ack) begin
            chk("u0.pending_runs", 32'(runs[0].size()), 32'd0);
            chk("u1.pending_runs", 32'(runs[1].size()), 32'd0);
            fin_ack = 1'b1;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // mode 0: plain run, expected changed mid-run
    // mode 1: start re-pulsed at cycle 10 of the run
    // mode 2: reset (with start high) at cycle 20 of the run
    // mode 3: start held high for two back-to-back runs
    task automatic run(input int g, input logic [15:0] tt, input logic [15:0] gold, input int mode);
        int   a;
        int   l;
        run_t r;
        l = 16 * period(g);
        @(negedge clk);
        tt_drv[g]  = tt;
        exp_v[g]   = gold;
        start_v[g] = 1'b1;
        a      = cyc + 1;
        r.acc  = a;
        r.tt   = tt;
        r.gold = gold;
        runs[g].push_back(r);
        if (mode != 3) begin
            @(negedge clk);
            start_v[g] = 1'b0;
        end
        case (mode)
            0: begin
                wait_cyc(a + 5);
                exp_v[g] = 16'($urandom);
                wait_cyc(a + l + 2);
            end
            1: begin
                wait_cyc(a + 9);
                start_v[g] = 1'b1;
                @(negedge clk);
                start_v[g] = 1'b0;
                wait_cyc(a + l + 2);
            end
            2: begin
                wait_cyc(a + 20);
                rst_v[g]   = 1'b1;
                start_v[g] = 1'b1;
                @(negedge clk);
                rst_v[g]   = 1'b0;
                start_v[g] = 1'b0;
                wait_cyc(a + l + 4);
            end
            default: begin
                // DONE at a+l, IDLE at a+l+1, second accept on edge a+l+2.
                wait_cyc(a + l + 1);
                r.acc = a + l + 2;
                runs[g].push_back(r);
                wait_cyc(a + 2 * l + 3);
                start_v[g] = 1'b0;
                wait_cyc(a + 2 * l + 5);
            end
        endcase
    endtask

    initial begin
        logic [15:0] gt;
        logic [15:0] tt;
        logic [15:0] gold;
        logic [3:0]  v;
        rst_v   = '{1'b1, 1'b1};
        start_v = '{1'b1, 1'b1};
        exp_v   = '{16'hFFFF, 16'hFFFF};
        tt_drv  = '{16'h0, 16'h0};
        st_tbl  = '{16'h0, 16'h0};
        st_pass = '{1'b0, 1'b0};
        st_vec  = '{4'h0, 4'h0};

        repeat (2) @(negedge clk);
        rst_v   = '{1'b0, 1'b0};
        start_v = '{1'b0, 1'b0};
        repeat (4) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            v     = 4'(i);
            gt[i] = two_level_f(v[3], v[2], v[1], v[0]);
        end

        run(0, gt, 16'hEFFF, 0);
        run(0, gt, 16'hFFFF, 0);
        run(1, 16'h0000, 16'h0000, 0);
        run(0, gt, 16'hEFFF, 1);
        run(0, 16'($urandom), 16'hEFFF, 2);
        run(0, gt, 16'hEFFF, 3);
        run(1, gt, 16'hEFFF, 3);

        for (int i = 0; i < 10; i++) begin
            tt = 16'($urandom);
            if ($urandom_range(0, 1) == 1) gold = tt;
            else gold = tt ^ (16'h1 << $urandom_range(0, 15));
            run(i % 2, tt, gold, (i % 3 == 0) ? 1 : 0);
        end

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clk);
        if (!fin_ack) begin
            $display("FAIL finalize: monitor did not report pending runs");
            $fatal(1, "monitor stalled");
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
